minirv_idu: RTL and testbench
=============================

Name: minirv_idu

Overview:
- Decode stage of the minirv core; sits directly upstream of the ALU.
- Accepts fetched instructions from the IFU over a valid/ready handshake and decodes the minirv subset.
- Reads the integer register file, which it owns, and presents alu_op, operand A/B and control to the EXU through a single-entry output register.
- Also owns the register-file write port driven by writeback.

Parameters:
- NREG, 16, number of architectural registers (RV32E); legal range 16 or 32.
- XLEN, 32, data width.

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  IFU has an instruction.
- in_ready  output  1  IDU can accept.
- in_inst  input  32  instruction word.
- in_pc  input  32  its PC.
- wb_en  input  1  register write strobe.
- wb_rd  input  5  destination index.
- wb_data  input  32  write data.
- out_valid  output  1  decoded bundle valid.
- out_ready  input  1  EXU accepts the bundle.
- out_alu_op  output  4  ALU operation; ALU_ADD for all legal instructions.
- out_a  output  32  operand A.
- out_b  output  32  operand B.
- out_sdata  output  32  store data (rs2).
- out_rd  output  5  destination register.
- out_rf_wen  output  1  instruction writes rd.
- out_mem  output  2  00 none, 01 load, 10 store.
- out_size  output  2  00 byte, 10 word.
- out_jalr  output  1  jump; next PC = result & ~1.
- out_link  output  32  in_pc + 4.
- out_ebreak  output  1  ebreak decoded.
- out_illegal  output  1  undecodable instruction.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - out_valid=0; all out_* bundle fields 0.
  - Registers x1..xN-1 cleared to 0.
  - in_ready=1 once rst is deasserted.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Transfer when in_valid && in_ready. The bundle is registered at that posedge, so latency is 1 cycle.
  - out_valid falls after out_valid && out_ready with no new transfer.
  - Bundle fields hold stable while out_valid && !out_ready.
  - Back-to-back transfers sustain 1 instruction/cycle.
- Decode, all legal instructions (alu_op=ALU_ADD):
  - add (opcode 0110011, f3 000, f7 0): a=rs1, b=rs2, wen=1.
  - addi (0010011, f3 000): a=rs1, b=sext(imm_i), wen=1.
  - lui (0110111): a=0, b={imm[31:12],12'b0}, wen=1.
  - lw/lbu (0000011, f3 010/100): a=rs1, b=imm_i, mem=01, size=10/00, wen=1.
  - sw/sb (0100011, f3 010/000): a=rs1, b=sext(imm_s), sdata=rs2, mem=10, wen=0.
  - jalr (1100111, f3 000): a=rs1, b=imm_i, jalr=1, wen=1; EXU writes link, not result.
  - ebreak (0x00100073): ebreak=1, wen=0, a=b=0.
- Illegal instructions:
  - Covers any other encoding, or any register field >= NREG.
  - Output: illegal=1, wen=0, mem=00, jalr=0, a=b=0, alu_op=ALU_ADD.
  - Bundle still flows through the handshake; the EXU raises the abort trap.
- Register file:
  - x0 reads 0; writes to rd=0 are dropped.
  - Write occurs at posedge when wb_en=1, independent of handshake state.
  - Same-cycle read of a register being written returns wb_data (bypass).
  - wb_rd >= NREG is ignored.
- Reset mid-operation: pending output bundle discarded (out_valid=0); wb write in that cycle dropped.

Decomposition:
- Shared defines file holds:
  - ALU_* op codes (ALU_ADD = 4'b0000).
  - Opcode constants.
  - Mem-type and size encodings.
  - ABORT/GOOD trap codes.
- One sub-module: minirv_regfile, parameter NREG. It provides 2 combinational read ports with write bypass and 1 synchronous write port.

Test Plan:
- Reset, then wb writes x5=0x10, issue addi x6,x5,-1 (0xFFF28313) -> next cycle out_valid=1, a=0x10, b=0xFFFFFFFF, rd=6, wen=1, alu_op=ALU_ADD.
- wb_en with rd=7, data 0xAB in the same cycle as accepting add x8,x7,x0 -> a=0xAB via bypass; write to x0 with 0x55 leaves a read of x0 at 0.
- out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0; bundle stable; no instruction lost. Release gives one transfer per cycle.
- sb x2,-4(x1) with x1=0x80000010, x2=0x1234 -> a=0x80000010, b=0xFFFFFFFC, sdata=0x1234, mem=10, size=00, wen=0.
- Inputs 0x00100073 and 0x00000000 -> first ebreak=1; second illegal=1, wen=0. add x17,x0,x0 with NREG=16 -> illegal=1.
- rst asserted while out_valid=1 && out_ready=0 -> out_valid=0 next cycle; x1..x15 read 0.

Source files
------------

// File: rtl/minirv_pkg.sv
// Shared encodings for the minirv core: ALU operations, opcodes, memory access
// types, trap codes and the control bundle handed from decode to execute.
package minirv_pkg;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLL  = 4'b0101;
   localparam logic [3:0] ALU_SRL  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_SLT  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_LW   = 3'b010;
   localparam logic [2:0] F3_LBU  = 3'b100;
   localparam logic [2:0] F3_SW   = 3'b010;
   localparam logic [2:0] F3_SB   = 3'b000;
   localparam logic [2:0] F3_JALR = 3'b000;
   localparam logic [6:0] F7_ADD  = 7'b0000000;

   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

   localparam logic [31:0] TRAP_GOOD  = 32'd0;
   localparam logic [31:0] TRAP_ABORT = 32'd1;

   typedef enum logic [1:0] {
      MEM_NONE  = 2'b00,
      MEM_LOAD  = 2'b01,
      MEM_STORE = 2'b10
   } mem_e;

   typedef enum logic [1:0] {
      SIZE_BYTE = 2'b00,
      SIZE_WORD = 2'b10
   } size_e;

   typedef struct packed {
      logic [3:0] alu_op;
      logic [4:0] rd;
      logic       rf_wen;
      mem_e       mem;
      size_e      size;
      logic       jalr;
      logic       ebreak;
      logic       illegal;
   } idu_ctrl_t;

   // One extra bit so that nreg = 32 is representable in the comparison.
   function automatic logic reg_in_range(input logic [4:0] idx, input int nreg);
      return {1'b0, idx} < 6'(nreg);
   endfunction

endpackage

// File: rtl/minirv_regfile.sv
// Integer register file: two combinational read ports with same-cycle write
// bypass, one synchronous write port; x0 is hardwired to zero.
module minirv_regfile
   import minirv_pkg::*;
#(
   parameter int NREG = 16,
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wen,
   input  logic [4:0]      waddr,
   input  logic [XLEN-1:0] wdata,
   input  logic [4:0]      raddr1,
   input  logic [4:0]      raddr2,
   output logic [XLEN-1:0] rdata1,
   output logic [XLEN-1:0] rdata2
);

   localparam int AW = $clog2(NREG);

   logic [XLEN-1:0] r_regs [NREG];
   logic            w_wr;
   logic            w_rd1_ok;
   logic            w_rd2_ok;

   assign w_wr     = wen && !rst && (waddr != 5'd0) && reg_in_range(waddr, NREG);
   assign w_rd1_ok = (raddr1 != 5'd0) && reg_in_range(raddr1, NREG);
   assign w_rd2_ok = (raddr2 != 5'd0) && reg_in_range(raddr2, NREG);

   // NOTE: the array is reset because architectural state must read zero after
   // reset; a storage array without that requirement would be left unreset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr) begin
         r_regs[waddr[AW-1:0]] <= wdata;
      end
   end

   assign rdata1 = !w_rd1_ok                   ? '0    :
                   (w_wr && (waddr == raddr1)) ? wdata :
                                                 r_regs[raddr1[AW-1:0]];

   assign rdata2 = !w_rd2_ok                   ? '0    :
                   (w_wr && (waddr == raddr2)) ? wdata :
                                                 r_regs[raddr2[AW-1:0]];

endmodule

// File: rtl/minirv_idu.sv
// minirv decode stage: decodes the instruction subset, reads the register file
// and holds one decoded bundle for the EXU behind a valid/ready handshake.
module minirv_idu
   import minirv_pkg::*;
#(
   parameter int NREG = 16,
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   input  logic [XLEN-1:0] in_pc,
   input  logic            wb_en,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [3:0]      out_alu_op,
   output logic [XLEN-1:0] out_a,
   output logic [XLEN-1:0] out_b,
   output logic [XLEN-1:0] out_sdata,
   output logic [4:0]      out_rd,
   output logic            out_rf_wen,
   output logic [1:0]      out_mem,
   output logic [1:0]      out_size,
   output logic            out_jalr,
   output logic [XLEN-1:0] out_link,
   output logic            out_ebreak,
   output logic            out_illegal
);

   logic [6:0]      w_opcode;
   logic [2:0]      w_f3;
   logic [6:0]      w_f7;
   logic [4:0]      w_rs1;
   logic [4:0]      w_rs2;
   logic [4:0]      w_rd;
   logic [XLEN-1:0] w_imm_i;
   logic [XLEN-1:0] w_imm_s;
   logic [XLEN-1:0] w_imm_u;
   logic [XLEN-1:0] w_rdata1;
   logic [XLEN-1:0] w_rdata2;

   logic            w_known;
   logic            w_use_rs1;
   logic            w_use_rs2;
   logic            w_use_rd;
   logic            w_regs_ok;
   idu_ctrl_t       w_ctrl;
   logic [XLEN-1:0] w_a;
   logic [XLEN-1:0] w_b;
   logic [XLEN-1:0] w_sdata;
   logic            w_xfer;

   logic            r_valid;
   idu_ctrl_t       r_ctrl;
   logic [XLEN-1:0] r_a;
   logic [XLEN-1:0] r_b;
   logic [XLEN-1:0] r_sdata;
   logic [XLEN-1:0] r_link;

   assign w_opcode = in_inst[6:0];
   assign w_rd     = in_inst[11:7];
   assign w_f3     = in_inst[14:12];
   assign w_rs1    = in_inst[19:15];
   assign w_rs2    = in_inst[24:20];
   assign w_f7     = in_inst[31:25];
   assign w_imm_i  = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
   assign w_imm_s  = {{(XLEN-12){in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
   assign w_imm_u  = {{(XLEN-32){in_inst[31]}}, in_inst[31:12], 12'b0};

   minirv_regfile #(
      .NREG (NREG),
      .XLEN (XLEN)
   ) u_regfile (
      .clk    (clk),
      .rst    (rst),
      .wen    (wb_en),
      .waddr  (wb_rd),
      .wdata  (wb_data),
      .raddr1 (w_rs1),
      .raddr2 (w_rs2),
      .rdata1 (w_rdata1),
      .rdata2 (w_rdata2)
   );

   // NOTE: every signal driven here gets a default first so that no path through
   // the case statement leaves it unassigned and infers a latch.
   always_comb begin
      w_known   = 1'b0;
      w_use_rs1 = 1'b0;
      w_use_rs2 = 1'b0;
      w_use_rd  = 1'b0;
      w_ctrl    = '0;
      w_ctrl.alu_op = ALU_ADD;
      w_a       = '0;
      w_b       = '0;
      w_sdata   = '0;

      case (w_opcode)
         OPC_OP: begin
            if (w_f3 == F3_ADD && w_f7 == F7_ADD) begin
               w_known   = 1'b1;
               w_use_rs1 = 1'b1;
               w_use_rs2 = 1'b1;
               w_use_rd  = 1'b1;
               w_a       = w_rdata1;
               w_b       = w_rdata2;
            end
         end
         OPC_OP_IMM: begin
            if (w_f3 == F3_ADD) begin
               w_known   = 1'b1;
               w_use_rs1 = 1'b1;
               w_use_rd  = 1'b1;
               w_a       = w_rdata1;
               w_b       = w_imm_i;
            end
         end
         OPC_LUI: begin
            w_known  = 1'b1;
            w_use_rd = 1'b1;
            w_b      = w_imm_u;
         end
         OPC_LOAD: begin
            if (w_f3 == F3_LW || w_f3 == F3_LBU) begin
               w_known     = 1'b1;
               w_use_rs1   = 1'b1;
               w_use_rd    = 1'b1;
               w_a         = w_rdata1;
               w_b         = w_imm_i;
               w_ctrl.mem  = MEM_LOAD;
               w_ctrl.size = (w_f3 == F3_LW) ? SIZE_WORD : SIZE_BYTE;
            end
         end
         OPC_STORE: begin
            if (w_f3 == F3_SW || w_f3 == F3_SB) begin
               w_known     = 1'b1;
               w_use_rs1   = 1'b1;
               w_use_rs2   = 1'b1;
               w_a         = w_rdata1;
               w_b         = w_imm_s;
               w_sdata     = w_rdata2;
               w_ctrl.mem  = MEM_STORE;
               w_ctrl.size = (w_f3 == F3_SW) ? SIZE_WORD : SIZE_BYTE;
            end
         end
         OPC_JALR: begin
            if (w_f3 == F3_JALR) begin
               w_known     = 1'b1;
               w_use_rs1   = 1'b1;
               w_use_rd    = 1'b1;
               w_a         = w_rdata1;
               w_b         = w_imm_i;
               w_ctrl.jalr = 1'b1;
            end
         end
         OPC_SYSTEM: begin
            if (in_inst == INST_EBREAK) begin
               w_known       = 1'b1;
               w_ctrl.ebreak = 1'b1;
            end
         end
         default: ;
      endcase

      // Only the register fields an instruction actually uses must name an
      // existing register; other bit positions belong to immediates.
      w_regs_ok = (!w_use_rs1 || reg_in_range(w_rs1, NREG)) &&
                  (!w_use_rs2 || reg_in_range(w_rs2, NREG)) &&
                  (!w_use_rd  || reg_in_range(w_rd,  NREG));

      if (w_known && w_regs_ok) begin
         w_ctrl.rf_wen = w_use_rd;
         w_ctrl.rd     = w_use_rd ? w_rd : 5'd0;
      end else begin
         w_ctrl         = '0;
         w_ctrl.alu_op  = ALU_ADD;
         w_ctrl.illegal = 1'b1;
         w_a            = '0;
         w_b            = '0;
         w_sdata        = '0;
      end
   end

   assign in_ready = !r_valid || out_ready;
   assign w_xfer   = in_valid && in_ready;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_ctrl  <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_sdata <= '0;
         r_link  <= '0;
      end else if (w_xfer) begin
         r_valid <= 1'b1;
         r_ctrl  <= w_ctrl;
         r_a     <= w_a;
         r_b     <= w_b;
         r_sdata <= w_sdata;
         r_link  <= in_pc + XLEN'(4);
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign out_valid   = r_valid;
   assign out_alu_op  = r_ctrl.alu_op;
   assign out_a       = r_a;
   assign out_b       = r_b;
   assign out_sdata   = r_sdata;
   assign out_rd      = r_ctrl.rd;
   assign out_rf_wen  = r_ctrl.rf_wen;
   assign out_mem     = r_ctrl.mem;
   assign out_size    = r_ctrl.size;
   assign out_jalr    = r_ctrl.jalr;
   assign out_link    = r_link;
   assign out_ebreak  = r_ctrl.ebreak;
   assign out_illegal = r_ctrl.illegal;

endmodule

// File: tb/tb_minirv_idu.sv
// Self-checking bench for minirv_idu: directed scenarios plus random traffic,
// expected bundles queued at acceptance and compared by an independent monitor.
`timescale 1ns/1ps
module tb_minirv_idu;

   localparam int NREG = 16;
   localparam int XLEN = 32;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_inst;
   logic [31:0] in_pc;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_alu_op;
   logic [31:0] out_a;
   logic [31:0] out_b;
   logic [31:0] out_sdata;
   logic [4:0]  out_rd;
   logic        out_rf_wen;
   logic [1:0]  out_mem;
   logic [1:0]  out_size;
   logic        out_jalr;
   logic [31:0] out_link;
   logic        out_ebreak;
   logic        out_illegal;

   minirv_idu #(.NREG(NREG), .XLEN(XLEN)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_inst     (in_inst),
      .in_pc       (in_pc),
      .wb_en       (wb_en),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_alu_op  (out_alu_op),
      .out_a       (out_a),
      .out_b       (out_b),
      .out_sdata   (out_sdata),
      .out_rd      (out_rd),
      .out_rf_wen  (out_rf_wen),
      .out_mem     (out_mem),
      .out_size    (out_size),
      .out_jalr    (out_jalr),
      .out_link    (out_link),
      .out_ebreak  (out_ebreak),
      .out_illegal (out_illegal)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  alu_op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] sdata;
      logic [4:0]  rd;
      logic        wen;
      logic [1:0]  mem;
      logic [1:0]  size;
      logic        jalr;
      logic [31:0] link;
      logic        ebreak;
      logic        illegal;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] m_rf [32];
   int          n_checks = 0;
   int          n_errors = 0;
   bit          last_xfer = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rf_read(input int idx);
      return (idx == 0) ? 32'd0 : m_rf[idx];
   endfunction

   // Reference decode straight from the instruction-set rules.
   function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
      exp_t e;
      bit   ok = 1;
      bit   need_rd = 0;
      bit   need_rs1 = 0;
      bit   need_rs2 = 0;
      int   op  = int'(w[6:0]);
      int   rd  = int'(w[11:7]);
      int   f3  = int'(w[14:12]);
      int   rs1 = int'(w[19:15]);
      int   rs2 = int'(w[24:20]);
      int   imm_i = $signed(w[31:20]);
      int   imm_s = $signed({w[31:25], w[11:7]});
      e = '{default: '0};
      if (w == 32'h0010_0073) begin
         e.ebreak = 1;
      end else if (op == 'h33 && f3 == 0 && w[31:25] == 0) begin
         need_rd = 1; need_rs1 = 1; need_rs2 = 1;
         e.a = rf_read(rs1); e.b = rf_read(rs2);
      end else if (op == 'h13 && f3 == 0) begin
         need_rd = 1; need_rs1 = 1;
         e.a = rf_read(rs1); e.b = 32'(imm_i);
      end else if (op == 'h37) begin
         need_rd = 1;
         e.b = w & 32'hFFFF_F000;
      end else if (op == 'h03 && (f3 == 2 || f3 == 4)) begin
         need_rd = 1; need_rs1 = 1;
         e.a = rf_read(rs1); e.b = 32'(imm_i);
         e.mem = 2'd1; e.size = (f3 == 2) ? 2'd2 : 2'd0;
      end else if (op == 'h23 && (f3 == 2 || f3 == 0)) begin
         need_rs1 = 1; need_rs2 = 1;
         e.a = rf_read(rs1); e.b = 32'(imm_s); e.sdata = rf_read(rs2);
         e.mem = 2'd2; e.size = (f3 == 2) ? 2'd2 : 2'd0;
      end else if (op == 'h67 && f3 == 0) begin
         need_rd = 1; need_rs1 = 1;
         e.a = rf_read(rs1); e.b = 32'(imm_i); e.jalr = 1;
      end else begin
         ok = 0;
      end
      if ((need_rd && rd >= NREG) || (need_rs1 && rs1 >= NREG) || (need_rs2 && rs2 >= NREG))
         ok = 0;
      if (!ok) begin
         e = '{default: '0};
         e.illegal = 1;
      end else if (need_rd) begin
         e.wen = 1;
         e.rd  = 5'(rd);
      end
      e.link = pc + 32'd4;
      return e;
   endfunction

   function automatic logic [31:0] enc_r(input int rd, input int rs1, input int rs2);
      return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'h33};
   endfunction
   function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                         input int rd, input int rs1, input logic [11:0] imm);
      return {imm, 5'(rs1), f3, 5'(rd), op};
   endfunction
   function automatic logic [31:0] enc_s(input logic [2:0] f3, input int rs1, input int rs2,
                                         input logic [11:0] imm);
      return {imm[11:5], 5'(rs2), 5'(rs1), f3, imm[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] rand_inst();
      int          r1  = $urandom_range(0, 17);
      int          r2  = $urandom_range(0, 17);
      int          rd  = $urandom_range(0, 17);
      logic [11:0] imm = 12'($urandom);
      case ($urandom_range(0, 10))
         0:  return enc_r(rd, r1, r2);
         1:  return enc_i(7'h13, 3'd0, rd, r1, imm);
         2:  return {20'($urandom), 5'(rd), 7'h37};
         3:  return enc_i(7'h03, 3'd2, rd, r1, imm);
         4:  return enc_i(7'h03, 3'd4, rd, r1, imm);
         5:  return enc_s(3'd2, r1, r2, imm);
         6:  return enc_s(3'd0, r1, r2, imm);
         7:  return enc_i(7'h67, 3'd0, rd, r1, imm);
         8:  return 32'h0010_0073;
         9:  return enc_r(rd, r1, r2) | 32'h4000_0000;
         default: return $urandom;
      endcase
   endfunction

   // One clock: decide acceptance and commit the model just before the edge.
   task automatic tick();
      exp_t e;
      bit   xfer;
      @(negedge clk);
      xfer = in_valid && in_ready && !rst;
      if (!rst) begin
         if (wb_en && wb_rd != 0 && wb_rd < NREG) m_rf[wb_rd] = wb_data;
         if (xfer) e = model(in_inst, in_pc);
      end
      @(posedge clk);
      if (rst) begin
         foreach (m_rf[i]) m_rf[i] = '0;
         sb_q.delete();
      end else if (xfer) begin
         sb_q.push_back(e);
      end
      last_xfer = xfer;
      #1;
   endtask

   task automatic send(input logic [31:0] inst, input logic [31:0] pc);
      bit done = 0;
      in_valid = 1; in_inst = inst; in_pc = pc;
      for (int k = 0; k < 50 && !done; k++) begin
         tick();
         wb_en = 0;
         done = last_xfer;
      end
      check("accept_timeout", 32'(done), 32'd1);
      in_valid = 0;
   endtask

   task automatic wb_write(input int rd, input logic [31:0] data);
      wb_en = 1; wb_rd = 5'(rd); wb_data = data;
      tick();
      wb_en = 0;
   endtask

   task automatic drain();
      in_valid = 0; out_ready = 1;
      tick(); tick();
   endtask

   // Monitor: every presented bundle must match the oldest outstanding one.
   initial begin
      exp_t act;
      forever begin
         @(negedge clk);
         if (out_valid === 1'b1) begin
            act = '{out_alu_op, out_a, out_b, out_sdata, out_rd, out_rf_wen, out_mem,
                    out_size, out_jalr, out_link, out_ebreak, out_illegal};
            n_checks++;
            if (sb_q.size() == 0) begin
               n_errors++;
               $display("FAIL bundle_unexpected: got a=%h b=%h rd=%0d with no outstanding instruction",
                        out_a, out_b, out_rd);
            end else begin
               if (act !== sb_q[0]) begin
                  n_errors++;
                  $display("FAIL bundle: got op=%h a=%h b=%h sd=%h rd=%0d wen=%b mem=%b sz=%b j=%b lnk=%h eb=%b ill=%b required op=%h a=%h b=%h sd=%h rd=%0d wen=%b mem=%b sz=%b j=%b lnk=%h eb=%b ill=%b",
                           act.alu_op, act.a, act.b, act.sdata, act.rd, act.wen, act.mem, act.size,
                           act.jalr, act.link, act.ebreak, act.illegal,
                           sb_q[0].alu_op, sb_q[0].a, sb_q[0].b, sb_q[0].sdata, sb_q[0].rd,
                           sb_q[0].wen, sb_q[0].mem, sb_q[0].size, sb_q[0].jalr, sb_q[0].link,
                           sb_q[0].ebreak, sb_q[0].illegal);
               end
               if (out_ready) void'(sb_q.pop_front());
            end
         end else begin
            n_checks++;
            if (out_valid !== 1'b0 || sb_q.size() != 0) begin
               n_errors++;
               $display("FAIL bundle_missing: got out_valid=%b with %0d outstanding, required 1",
                        out_valid, sb_q.size());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1; in_valid = 0; in_inst = '0; in_pc = '0;
      wb_en = 0; wb_rd = '0; wb_data = '0; out_ready = 1;
      foreach (m_rf[i]) m_rf[i] = '0;
      tick(); tick();
      rst = 0;

      // Reset state
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_a", out_a, 0);
      check("rst_b", out_b, 0);
      check("rst_sdata", out_sdata, 0);
      check("rst_link", out_link, 0);
      check("rst_ctrl", 32'({out_alu_op, out_rd, out_rf_wen, out_mem, out_size,
                             out_jalr, out_ebreak, out_illegal}), 0);

      // addi x6,x5,-1 with x5 = 0x10; bundle due one cycle after acceptance
      wb_write(5, 32'h10);
      send(32'hFFF2_8313, 32'h100);
      check("addi_valid", 32'(out_valid), 1);
      check("addi_a", out_a, 32'h10);
      check("addi_b", out_b, 32'hFFFF_FFFF);
      check("addi_rd", 32'(out_rd), 6);
      check("addi_wen", 32'(out_rf_wen), 1);
      check("addi_op", 32'(out_alu_op), 0);

      // Same-cycle writeback bypass, and x0 stays zero
      wb_en = 1; wb_rd = 7; wb_data = 32'hAB;
      send(enc_r(8, 7, 0), 32'h104);
      check("bypass_a", out_a, 32'hAB);
      wb_en = 1; wb_rd = 0; wb_data = 32'h55;
      send(enc_r(9, 0, 0), 32'h108);
      check("x0_a", out_a, 0);

      // Stall: EXU blocks for three cycles
      drain();
      out_ready = 0;
      send(enc_i(7'h13, 3'd0, 1, 0, 12'd1), 32'h200);
      in_valid = 1; in_inst = enc_i(7'h13, 3'd0, 2, 0, 12'd2); in_pc = 32'h204;
      for (int k = 0; k < 3; k++) begin
         check("stall_in_ready", 32'(in_ready), 0);
         tick();
         check("stall_no_xfer", 32'(last_xfer), 0);
      end
      out_ready = 1;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("stream_xfer", 32'(last_xfer), 1);
         in_inst = enc_i(7'h13, 3'd0, 3 + k, 0, 12'(k)); in_pc = 32'h208 + 32'(4 * k);
      end
      drain();

      // sb x2,-4(x1)
      wb_write(1, 32'h8000_0010);
      wb_write(2, 32'h1234);
      send(enc_s(3'd0, 1, 2, 12'hFFC), 32'h300);
      check("sb_a", out_a, 32'h8000_0010);
      check("sb_b", out_b, 32'hFFFF_FFFC);
      check("sb_sdata", out_sdata, 32'h1234);
      check("sb_mem", 32'(out_mem), 2);
      check("sb_size", 32'(out_size), 0);
      check("sb_wen", 32'(out_rf_wen), 0);

      // ebreak, all-zero word, out-of-range register
      send(32'h0010_0073, 32'h400);
      check("ebreak", 32'(out_ebreak), 1);
      send(32'h0000_0000, 32'h404);
      check("zero_illegal", 32'(out_illegal), 1);
      check("zero_wen", 32'(out_rf_wen), 0);
      send(enc_r(17, 0, 0), 32'h408);
      check("x17_illegal", 32'(out_illegal), 1);
      drain();

      // Random traffic
      for (int c = 0; c < 400; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         in_inst   = rand_inst();
         in_pc     = $urandom & 32'hFFFF_FFFC;
         wb_en     = $urandom_range(0, 1) == 1;
         wb_rd     = 5'($urandom_range(0, 31));
         wb_data   = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      wb_en = 0;
      drain();

      // Reset while a stalled bundle is pending, with a writeback in flight
      out_ready = 0;
      send(enc_i(7'h13, 3'd0, 4, 0, 12'd9), 32'h500);
      rst = 1; wb_en = 1; wb_rd = 3; wb_data = 32'h99; in_valid = 1;
      tick();
      rst = 0; wb_en = 0; in_valid = 0; out_ready = 1;
      check("midrst_valid", 32'(out_valid), 0);
      for (int i = 1; i < NREG; i++) begin
         send(enc_r(1, i, 0), 32'h600 + 32'(4 * i));
         check("midrst_rf_zero", out_a, 0);
      end
      drain();
      check("queue_empty", 32'(sb_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
